morse_transmitter: RTL and testbench
====================================

Name: morse_transmitter

Overview:
- Serial transmitter that plays back a Morse code pattern for one of eight letters, A through H, on a single LED output.
- It is the generating end of the same single-bit serial stream our sequence-detecting FSMs consume: a detector takes in a bit stream, this block produces one.
- It sits directly under the DE1-SoC top level. SW selects the letter, a KEY pulse (synchronised upstream into `start`) triggers playback, and LEDR shows the stream.
- A unit timer sets symbol timing: dot = 1 unit on, dash = 3 units on, inter-symbol gap = 1 unit off.

Parameters:
- TICKS_PER_UNIT, 25000000: clock cycles per Morse time unit (0.5 s at 50 MHz). Must be ≥ 2. Benches use 4.
- CNT_W, 25: width of the unit tick counter. Must satisfy 2^CNT_W ≥ TICKS_PER_UNIT.

Ports:
- clk  input  1  system clock; every register updates on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle request to begin playback; sampled only in IDLE.
- letter  input  3  letter select: 0=A, 1=B, 2=C, 3=D, 4=E, 5=F, 6=G, 7=H. Sampled on the cycle start is accepted.
- led_out  output  1  Morse stream: 1 = tone/light on.
- busy  output  1  high from the cycle after start is accepted until playback finishes.
- done  output  1  one-cycle pulse when playback completes.
- state_dbg  output  2  current FSM state encoding, for LEDR display.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE, led_out=0, busy=0, done=0.
  - Shift register, length counter and tick counter all 0.
  - This takes effect mid-playback too: the LED goes dark immediately and no done pulse is produced.
- Code table, as length / pattern; pattern is MSB-first, 1 = dash, left-justified in 4 bits:
  - A 2/0100
  - B 4/1000
  - C 4/1010
  - D 3/1000
  - E 1/0000
  - F 4/0010
  - G 3/1100
  - H 4/0000
- States: IDLE=00, ON=01, GAP=10; 11 is unused and recovers to IDLE on the next edge.
- IDLE:
  - led_out=0, busy=0.
  - On a clock edge with start=1: load the pattern into the 4-bit shift register and the length into the symbol counter, clear the tick counter, clear the unit counter, go to ON.
- ON:
  - led_out=1, busy=1.
  - The tick counter increments each cycle; when it reaches TICKS_PER_UNIT-1 it wraps to 0 and the unit counter increments.
  - The symbol is complete when the unit counter would reach 1 (dot, shift MSB=0) or 3 (dash, shift MSB=1).
  - On completion: shift left by 1, decrement the symbol counter, clear both counters, go to GAP.
  - Result: the LED is high for exactly TICKS_PER_UNIT or 3×TICKS_PER_UNIT consecutive cycles.
- GAP:
  - led_out=0, busy=1. Lasts exactly TICKS_PER_UNIT cycles.
  - At the end, if the symbol counter is nonzero: clear counters, go to ON.
  - Otherwise: go to IDLE and assert done=1 for that one cycle (the first IDLE cycle).
- The trailing gap is always played, so two back-to-back letters remain separable.
- led_out, busy and done are registered outputs; none is a combinational function of inputs.
- Latency: start accepted at edge k → led_out=1 and busy=1 from the cycle following edge k.
- Total busy duration = Σ(symbol units) × TICKS_PER_UNIT + length × TICKS_PER_UNIT cycles.
- start while busy=1 is ignored; the letter change is not re-sampled.
- start asserted in the same cycle done is high: accepted (the state is IDLE), and playback restarts with no extra idle cycle.
- start held high for many cycles in IDLE: exactly one playback begins. It re-triggers only if still high when IDLE is re-entered, which is the documented level-sensitive behaviour.

Decomposition:
- Shared package (morse_pkg):
  - state encodings IDLE/ON/GAP;
  - DOT_UNITS=1, DASH_UNITS=3, GAP_UNITS=1;
  - letter-index constants.
- One sub-module is natural: morse_rom, a combinational letter[2:0] → {length[2:0], pattern[3:0]} lookup.
- The top module holds the FSM, the shift register and the counters.

Test Plan (TICKS_PER_UNIT=4):
- Reset then idle: reset_n=0 for 3 cycles, release → led_out=0, busy=0, done=0, state_dbg=00 for 20 cycles with start=0.
- Letter E (4): start pulse → led_out high 4 cycles, low 4 cycles, then done=1 for exactly one cycle. busy high for exactly 8 cycles.
- Letter A (0): led_out pattern 1×4, 0×4, 1×12, 0×4 → done pulse at cycle 25 after start. 24 busy cycles.
- Letter B (1): on-runs of 12,4,4,4 cycles, each separated by 4 low cycles → done after 40 busy cycles. Also change letter to H mid-playback; the output is unchanged.
- Start while busy: pulse start with letter=7 during the second symbol of C (2) → C completes unaltered (12,4,12,4 on-runs), and no H playback follows.
- Reset mid-operation: assert reset_n=0 asynchronously (between edges) during an ON interval of G → led_out=0 and busy=0 immediately. No done pulse; after release, state_dbg=00 and a new start plays G from its first dash.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared constants for the Morse letter transmitter.
// State codes, symbol timing in units and letter indices.
package morse_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_ON   = 2'b01;
  localparam logic [1:0] ST_GAP  = 2'b10;

  localparam logic [1:0] DOT_UNITS  = 2'd1;
  localparam logic [1:0] DASH_UNITS = 2'd3;
  localparam logic [1:0] GAP_UNITS  = 2'd1;

  localparam logic [2:0] LTR_A = 3'd0;
  localparam logic [2:0] LTR_B = 3'd1;
  localparam logic [2:0] LTR_C = 3'd2;
  localparam logic [2:0] LTR_D = 3'd3;
  localparam logic [2:0] LTR_E = 3'd4;
  localparam logic [2:0] LTR_F = 3'd5;
  localparam logic [2:0] LTR_G = 3'd6;
  localparam logic [2:0] LTR_H = 3'd7;

  typedef struct packed {
    logic [2:0] len;
    logic [3:0] pat;
  } morse_code_t;

endpackage

// File: rtl/morse_transmitter_if.sv
// Request and stream bundle between the board top and
// the Morse transmitter.
interface morse_transmitter_if;

  logic       start;
  logic [2:0] letter;
  logic       led_out;
  logic       busy;
  logic       done;
  logic [1:0] state_dbg;

  modport master (
    output start, letter,
    input  led_out, busy, done, state_dbg
  );

  modport slave (
    input  start, letter,
    output led_out, busy, done, state_dbg
  );

endinterface

// File: rtl/morse_rom.sv
// Letter to Morse code lookup, A..H.
// Pattern is MSB-first, 1 = dash, left-justified.
module morse_rom
  import morse_pkg::*;
(
  input  logic [2:0]  letter,
  output morse_code_t code
);

  // Fixed code table.
  always_comb begin
    code = '0;
    unique case (letter)
      LTR_A: code = '{len: 3'd2, pat: 4'b0100};
      LTR_B: code = '{len: 3'd4, pat: 4'b1000};
      LTR_C: code = '{len: 3'd4, pat: 4'b1010};
      LTR_D: code = '{len: 3'd3, pat: 4'b1000};
      LTR_E: code = '{len: 3'd1, pat: 4'b0000};
      LTR_F: code = '{len: 3'd4, pat: 4'b0010};
      LTR_G: code = '{len: 3'd3, pat: 4'b1100};
      LTR_H: code = '{len: 3'd4, pat: 4'b0000};
      default: code = '0;
    endcase
  end

endmodule

// File: rtl/morse_transmitter.sv
// Plays one Morse letter on a single LED line.
// Dot 1 unit on, dash 3 units on, 1 unit off after each.
module morse_transmitter
  import morse_pkg::*;
#(
  parameter int TICKS_PER_UNIT = 25000000,
  parameter int CNT_W          = 25
) (
  input logic                 clk,
  input logic                 reset_n,
  morse_transmitter_if.slave  bus
);

  logic [1:0]       state;
  logic [3:0]       shreg;
  logic [2:0]       symcnt;
  logic [CNT_W-1:0] tick;
  logic [1:0]       units;
  logic             led_q;
  logic             busy_q;
  logic             done_q;

  morse_code_t code;

  logic       tick_end;
  logic [1:0] units_nx;
  logic [1:0] sym_units;

  morse_rom u_rom (
    .letter (bus.letter),
    .code   (code)
  );

  assign tick_end  = (tick == CNT_W'(TICKS_PER_UNIT - 1));
  assign units_nx  = units + 2'd1;
  assign sym_units = shreg[3] ? DASH_UNITS : DOT_UNITS;

  // FSM, shift register, counters and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      shreg  <= '0;
      symcnt <= '0;
      tick   <= '0;
      units  <= '0;
      led_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (bus.start) begin
            shreg  <= code.pat;
            symcnt <= code.len;
            tick   <= '0;
            units  <= '0;
            state  <= ST_ON;
            led_q  <= 1'b1;
            busy_q <= 1'b1;
          end
        end
        ST_ON: begin
          if (!tick_end) begin
            tick <= tick + CNT_W'(1);
          end else begin
            tick <= '0;
            if (units_nx == sym_units) begin
              shreg  <= {shreg[2:0], 1'b0};
              symcnt <= symcnt - 3'd1;
              units  <= '0;
              state  <= ST_GAP;
              led_q  <= 1'b0;
            end else begin
              units <= units_nx;
            end
          end
        end
        ST_GAP: begin
          if (!tick_end) begin
            tick <= tick + CNT_W'(1);
          end else begin
            tick <= '0;
            if (units_nx == GAP_UNITS) begin
              units <= '0;
              if (symcnt != 3'd0) begin
                state <= ST_ON;
                led_q <= 1'b1;
              end else begin
                state  <= ST_IDLE;
                busy_q <= 1'b0;
                done_q <= 1'b1;
              end
            end else begin
              units <= units_nx;
            end
          end
        end
        default: begin
          state  <= ST_IDLE;
          led_q  <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.led_out   = led_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_morse_transmitter.sv
// Bench for morse_transmitter: queue-based stream model
// plus literal run-length and timing checks.
module tb_morse_transmitter;

  localparam int T = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   vec = 0;
  int   errs = 0;
  bit   chk_on = 1'b0;

  morse_transmitter_if bus ();

  morse_transmitter #(
    .TICKS_PER_UNIT (T),
    .CNT_W          (3)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  string codes [8] = '{".-", "-...", "-.-.", "-..",
                       ".", "..-.", "--.", "...."};

  bit q[$];
  bit exp_done = 1'b0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d want %0d @%0t",
               name, act, exp, $time);
    end
  endtask

  function automatic void build(input logic [2:0] l);
    string s;
    int n;
    s = codes[l];
    q.delete();
    for (int i = 0; i < s.len(); i++) begin
      n = (s[i] == "-") ? 3 * T : T;
      for (int j = 0; j < n; j++) q.push_back(1'b1);
      for (int j = 0; j < T; j++) q.push_back(1'b0);
    end
  endfunction

  // Model: one queue entry per remaining busy cycle.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
      exp_done = 1'b0;
    end else begin
      exp_done = 1'b0;
      if (q.size() > 0) begin
        void'(q.pop_front());
        if (q.size() == 0) exp_done = 1'b1;
      end else if (bus.start) begin
        build(bus.letter);
      end
    end
  end

  // Compare every cycle against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      logic el;
      logic eb;
      logic [1:0] es;
      el = (q.size() > 0) ? q[0] : 1'b0;
      eb = (q.size() > 0);
      es = el ? 2'b01 : (eb ? 2'b10 : 2'b00);
      chk("led", bus.led_out, el);
      chk("busy", bus.busy, eb);
      chk("done", bus.done, exp_done);
      chk("state", bus.state_dbg, es);
    end
  end

  task automatic run_letter(input logic [2:0] l,
                            input int exp_busy,
                            input int er [4],
                            input int enr);
    int runs [8];
    int nr;
    int cur;
    int nb;
    int cyc;
    bit seen;
    nr = 0; cur = 0; nb = 0; cyc = 0; seen = 0;
    @(posedge clk); #2;
    bus.letter = l;
    bus.start = 1'b1;
    @(posedge clk); #2;
    bus.start = 1'b0;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge clk);
      cyc++;
      if (bus.done) begin
        seen = 1'b1;
      end else begin
        if (bus.busy) nb++;
        if (bus.led_out) begin
          cur++;
        end else if (cur > 0) begin
          if (nr < 8) runs[nr] = cur;
          nr++;
          cur = 0;
        end
      end
    end
    chk("done_seen", seen, 1);
    chk("busy_len", nb, exp_busy);
    chk("done_cyc", cyc, exp_busy + 1);
    chk("n_runs", nr, enr);
    for (int i = 0; i < enr && i < nr && i < 4; i++)
      chk("run_len", runs[i], er[i]);
    @(negedge clk);
    chk("done_1cyc", bus.done, 0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.letter = 3'd0;
    reset_n = 1'b0;
    @(posedge clk);
    chk_on = 1'b1;
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    repeat (20) @(posedge clk);
    #2;
    chk("idle_led", bus.led_out, 0);
    chk("idle_busy", bus.busy, 0);
    chk("idle_state", bus.state_dbg, 0);

    run_letter(3'd4, 8, '{4, 0, 0, 0}, 1);
    repeat (3) @(posedge clk);
    run_letter(3'd0, 24, '{4, 12, 0, 0}, 2);
    repeat (3) @(posedge clk);

    fork
      run_letter(3'd1, 40, '{12, 4, 4, 4}, 4);
      begin
        repeat (10) @(posedge clk);
        #2 bus.letter = 3'd7;
      end
    join
    repeat (3) @(posedge clk);

    fork
      run_letter(3'd2, 48, '{12, 4, 12, 4}, 4);
      begin
        repeat (20) @(posedge clk);
        #2;
        bus.letter = 3'd7;
        bus.start = 1'b1;
        @(posedge clk); #2;
        bus.start = 1'b0;
      end
    join
    repeat (12) @(negedge clk);
    chk("no_h_busy", bus.busy, 0);

    @(posedge clk); #2;
    bus.letter = 3'd6;
    bus.start = 1'b1;
    @(posedge clk); #2;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    chk("g_on", bus.led_out, 1);
    reset_n = 1'b0;
    #1;
    chk("rst_led", bus.led_out, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    chk("rst_state", bus.state_dbg, 0);
    repeat (3) @(posedge clk);
    run_letter(3'd6, 40, '{12, 12, 4, 0}, 3);

    repeat (5) @(posedge clk);
    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==",
             vec, errs);
    $finish;
  end

endmodule
